// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, registers each fetched word into a
// one-entry valid/ready output stage, and handles execute redirects and end-of-image.
module fetch_unit #(
   parameter int unsigned MEM_BYTES = 32,
   parameter int unsigned RESET_PC  = 0
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] pc,
   input  logic [31:0] instr_in,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic        done,
   output logic        misaligned_err
);

   localparam logic [31:0] MEM_LIMIT  = 32'(MEM_BYTES);
   localparam logic [31:0] LAST_PC    = 32'(MEM_BYTES - 4);
   localparam logic [31:0] RESET_ADDR = 32'(RESET_PC);

   typedef enum logic [1:0] {
      S_RUN = 2'd0,
      S_END = 2'd1,
      S_ERR = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] pc_nxt;
   logic [31:0] if_instr_nxt;
   logic [31:0] if_pc_nxt;
   logic        if_valid_nxt;
   logic        done_nxt;
   logic        err_nxt;
   logic        accept_c;
   logic        target_ok_c;

   // Output stage can take a new word when empty or being drained this cycle
   assign accept_c    = !if_valid || if_ready;
   assign target_ok_c = (redirect_pc[1:0] == 2'b00) && (redirect_pc < MEM_LIMIT);

   // Next-state and next-output logic
   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      if_instr_nxt = if_instr;
      if_pc_nxt    = if_pc;
      if_valid_nxt = if_valid;
      err_nxt      = misaligned_err;
      // done lags state/if_valid by one register stage
      done_nxt     = (state == S_END) && !if_valid;

      unique case (state)
         S_RUN, S_END: begin
            if (redirect_valid) begin
               // Redirect flushes the stage and takes priority over fetch
               if_valid_nxt = 1'b0;
               if (target_ok_c) begin
                  pc_nxt    = redirect_pc;
                  state_nxt = S_RUN;
               end else begin
                  err_nxt   = 1'b1;
                  state_nxt = S_ERR;
               end
            end else if (accept_c) begin
               if (state == S_RUN) begin
                  if_instr_nxt = instr_in;
                  if_pc_nxt    = pc;
                  if_valid_nxt = 1'b1;
                  if (pc == LAST_PC) begin
                     state_nxt = S_END;
                  end else begin
                     pc_nxt = pc + 32'd4;
                  end
               end else begin
                  if_valid_nxt = 1'b0;
               end
            end
         end
         S_ERR: begin
            if (accept_c) begin
               if_valid_nxt = 1'b0;
            end
         end
         default: begin
            state_nxt = S_ERR;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= S_RUN;
         pc             <= RESET_ADDR;
         if_valid       <= 1'b0;
         if_instr       <= 32'd0;
         if_pc          <= 32'd0;
         done           <= 1'b0;
         misaligned_err <= 1'b0;
      end else begin
         state          <= state_nxt;
         pc             <= pc_nxt;
         if_valid       <= if_valid_nxt;
         if_instr       <= if_instr_nxt;
         if_pc          <= if_pc_nxt;
         done           <= done_nxt;
         misaligned_err <= err_nxt;
      end
   end

endmodule
